// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the uart_tx scheduler: FSM encoding, hex helper, baud constant.
// Optional hex-dump mode is enabled by defining UART_SCHED_HEX_EN.
package uart_tx_sched_pkg;

    localparam int unsigned CLK_HZ       = 48000000;
    localparam int unsigned BAUD         = 115200;
    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;

`ifdef UART_SCHED_HEX_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACCEPT    = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_ACT  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_HEX_LO    = 3'd5
    } sched_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACCEPT    = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_ACT  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } sched_state_e;
`endif

    // Uppercase ASCII character for one nibble.
    function automatic logic [7:0] nib2hex(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin picker: first requesting port at or after the pointer, one-hot out.
module uart_tx_sched_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic             found;
    logic [IDX_W-1:0] pos;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            pos = IDX_W'((32'(ptr_i) + off) % NUM_REQ);
            if (!found && req_i[pos]) begin
                gnt_o[pos] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin, packet-locking scheduler feeding one uart_tx serializer from NUM_REQ byte streams.
// Define UART_SCHED_HEX_EN to send HEX_MASK-selected ports as two ASCII hex characters per byte.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned LOCK_TIMEOUT = 4800,
    parameter logic [7:0]  HEX_MASK     = 8'h00
) (
    input  logic                   clk48,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_dv,
    output logic [7:0]             tx_byte,
    input  logic                   tx_active,
    input  logic                   tx_done,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

    sched_state_e       state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   rr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               tx_dv_q;
    logic [7:0]         tx_byte_q;
    logic               last_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   rr_next_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;

`ifdef UART_SCHED_HEX_EN
    logic [3:0]         lo_nib_q;
    logic               hex_pend_q;
`else
    // HEX_MASK has no effect without the hex feature.
    logic               unused_hex_mask;
    assign unused_hex_mask = ^HEX_MASK;
`endif

    uart_tx_sched_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt)
    );

    // Encode arbiter grant; mux the owner's request signals.
    always_comb begin
        arb_idx   = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                arb_idx = IDX_W'(i);
            end
            if (idx_q == IDX_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    assign rr_next_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
    assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    assign req_ready = (state_q == ST_ACCEPT) ? (grant_q & req_valid) : '0;
    assign tx_dv     = tx_dv_q;
    assign tx_byte   = tx_byte_q;
    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge clk48) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            last_q    <= 1'b0;
`ifdef UART_SCHED_HEX_EN
            lo_nib_q   <= 4'h0;
            hex_pend_q <= 1'b0;
`endif
        end else begin
            tx_dv_q <= 1'b0;
            case (state_q)
                // uart_tx may still be finishing a frame from before reset.
                ST_IDLE: begin
                    if (!tx_active && (|req_valid)) begin
                        grant_q <= arb_gnt;
                        idx_q   <= arb_idx;
                        cnt_q   <= '0;
                        state_q <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (sel_valid) begin
                        tx_byte_q <= sel_data;
                        last_q    <= sel_last;
                        cnt_q     <= '0;
                        tx_dv_q   <= 1'b1;
                        state_q   <= ST_LOAD;
`ifdef UART_SCHED_HEX_EN
                        if (HEX_MASK[idx_q]) begin
                            tx_byte_q  <= nib2hex(sel_data[7:4]);
                            lo_nib_q   <= sel_data[3:0];
                            hex_pend_q <= 1'b1;
                        end
`endif
                    end else if (cnt_d == CNT_W'(LOCK_TIMEOUT)) begin
                        grant_q <= '0;
                        rr_q    <= rr_next_d;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_WAIT_ACT;
                end
                ST_WAIT_ACT: begin
                    if (tx_active) begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
`ifdef UART_SCHED_HEX_EN
                    if (tx_done && hex_pend_q) begin
                        state_q <= ST_HEX_LO;
                    end else
`endif
                    if (tx_done) begin
                        if (last_q) begin
                            grant_q <= '0;
                            rr_q    <= rr_next_d;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= ST_ACCEPT;
                        end
                    end
                end
`ifdef UART_SCHED_HEX_EN
                ST_HEX_LO: begin
                    tx_byte_q  <= nib2hex(lo_nib_q);
                    hex_pend_q <= 1'b0;
                    tx_dv_q    <= 1'b1;
                    state_q    <= ST_LOAD;
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched with a short-frame uart_tx stand-in.
// Define UART_SCHED_HEX_EN to also exercise the hex-dump path on port 1.
module tb_uart_tx_sched;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned LTO   = 4800;
    localparam int unsigned FRAME = 12;
`ifdef UART_SCHED_HEX_EN
    localparam logic [7:0] TB_HEX_MASK = 8'h02;
`else
    localparam logic [7:0] TB_HEX_MASK = 8'h00;
`endif

    logic            clk48 = 1'b0;
    logic            rst   = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [15:0]     req_data  = '0;
    logic [NREQ-1:0] req_last  = '0;
    logic [NREQ-1:0] req_ready;
    logic            tx_dv;
    logic [7:0]      tx_byte;
    logic            tx_active = 1'b0;
    logic            tx_done   = 1'b0;
    logic [NREQ-1:0] grant;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [15:0] log_q[$];
    logic [NREQ-1:0] hs = '0;
    int ready_bad = 0;
    int unstable  = 0;
    int dv_total  = 0;
    int dv_logged = 0;
    int unsigned ucnt = 0;
    logic [7:0]  ubyte = 8'h00;
    logic        uskip = 1'b0;

    always #5 clk48 = ~clk48;

    uart_tx_sched #(
        .NUM_REQ      (NREQ),
        .LOCK_TIMEOUT (LTO),
        .HEX_MASK     (TB_HEX_MASK)
    ) dut (
        .clk48     (clk48),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .grant     (grant),
        .busy      (busy)
    );

    // uart_tx stand-in: active from 2 cycles after tx_dv, done pulse after FRAME cycles; never reset.
    always @(posedge clk48) begin
        tx_done <= 1'b0;
        if (tx_dv) dv_total <= dv_total + 1;
        if (tx_dv && ucnt == 0) begin
            ucnt      <= 1;
            ubyte     <= tx_byte;
            uskip     <= 1'b0;
            dv_logged <= dv_logged + 1;
            log_q.push_back({6'b0, grant, tx_byte});
        end else if (ucnt != 0) begin
            if (rst) uskip <= 1'b1;
            else if (!uskip && tx_byte !== ubyte) unstable <= unstable + 1;
            if (ucnt == 2) tx_active <= 1'b1;
            if (ucnt == FRAME) begin
                tx_active <= 1'b0;
                tx_done   <= 1'b1;
                ucnt      <= 0;
            end else begin
                ucnt <= ucnt + 1;
            end
        end
    end

    // One clock: retire handshaken bytes, then present queue heads and sample at negedge+1.
    task automatic tick();
        @(posedge clk48);
        if (hs[0]) void'(q0.pop_front());
        if (hs[1]) void'(q1.pop_front());
        @(negedge clk48);
        req_valid[0]   = (q0.size() != 0);
        req_data[7:0]  = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
        req_last[0]    = (q0.size() != 0) ? q0[0][8] : 1'b0;
        req_valid[1]   = (q1.size() != 0);
        req_data[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
        req_last[1]    = (q1.size() != 0) ? q1[0][8] : 1'b0;
        #1;
        hs = req_ready & req_valid;
        if ((req_ready & ~grant) != '0 || $countones(req_ready) > 1) ready_bad++;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy && !tx_active && q0.size() == 0 && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        q0.delete();
        q1.delete();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        q0.push_back({1'b1, 8'h99});
        rst = 1'b1;
        tick(); tick(); tick();
        checks++; if (tx_dv !== 1'b0)     begin failures++; $display("FAIL reset_tx_dv got=%b exp=0", tx_dv); end
        checks++; if (tx_byte !== 8'h00)  begin failures++; $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); end
        checks++; if (grant !== 2'b00)    begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        q0.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_latency();
        bit ok;
        q0.push_back({1'b1, 8'h5A});
        tick();
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL lat_n_grant got=%b exp=00", grant); end
        tick();
        checks++; if (grant !== 2'b01 || req_ready !== 2'b01 || tx_dv !== 1'b0) begin
            failures++; $display("FAIL lat_n1 grant=%b ready=%b dv=%b exp 01/01/0", grant, req_ready, tx_dv); end
        tick();
        checks++; if (tx_dv !== 1'b1 || tx_byte !== 8'h5A) begin
            failures++; $display("FAIL lat_n2 dv=%b byte=%h exp 1/5a", tx_dv, tx_byte); end
        tick();
        checks++; if (tx_dv !== 1'b0) begin failures++; $display("FAIL lat_dv_width got=%b exp=0", tx_dv); end
        wait_idle(100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL lat_idle got=timeout exp=idle"); end
    endtask

    task automatic test_packet_ok();
        bit started = 1'b0;
        int gaps = 0;
        int r1 = 0;
        log_q.delete();
        q0.push_back({1'b0, 8'h4F});
        q0.push_back({1'b0, 8'h4B});
        q0.push_back({1'b1, 8'h0A});
        for (int i = 0; i < 400; i++) begin
            tick();
            if (req_ready[1]) r1++;
            if (!started && grant == 2'b01) started = 1'b1;
            if (started && busy && grant !== 2'b01) gaps++;
            if (started && !busy) break;
        end
        checks++; if (log_q.size() != 3) begin failures++; $display("FAIL ok_count got=%0d exp=3", log_q.size()); end
        checks++; if (log_q[0] !== 16'h014F) begin failures++; $display("FAIL ok_byte0 got=%h exp=014f", log_q[0]); end
        checks++; if (log_q[1] !== 16'h014B) begin failures++; $display("FAIL ok_byte1 got=%h exp=014b", log_q[1]); end
        checks++; if (log_q[2] !== 16'h010A) begin failures++; $display("FAIL ok_byte2 got=%h exp=010a", log_q[2]); end
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL ok_grant_end got=%b exp=00", grant); end
        checks++; if (gaps != 0 || r1 != 0) begin failures++; $display("FAIL ok_lock gaps=%0d ready1=%0d exp 0/0", gaps, r1); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        do_reset();
        log_q.delete();
        q0.push_back({1'b1, 8'h41});
        q1.push_back({1'b1, 8'h42});
        wait_idle(300, ok);
        q0.push_back({1'b1, 8'h43});
        q1.push_back({1'b1, 8'h44});
        wait_idle(300, ok);
        checks++; if (!ok || log_q.size() != 4) begin failures++; $display("FAIL sim_count got=%0d ok=%0d exp=4", log_q.size(), ok); end
        checks++; if (log_q[0] !== 16'h0141) begin failures++; $display("FAIL sim_first got=%h exp=0141", log_q[0]); end
        checks++; if (log_q[1] !== 16'h0242) begin failures++; $display("FAIL sim_second got=%h exp=0242", log_q[1]); end
        checks++; if (log_q[2] !== 16'h0143 || log_q[3] !== 16'h0244) begin
            failures++; $display("FAIL sim_rr_wrap got=%h,%h exp=0143,0244", log_q[2], log_q[3]); end
    endtask

    task automatic test_lock();
        bit ok = 1'b0;
        log_q.delete();
        q0.push_back({1'b0, 8'h10});
        q0.push_back({1'b0, 8'h11});
        q0.push_back({1'b1, 8'h12});
        for (int i = 0; i < 100; i++) begin
            tick();
            if (log_q.size() >= 1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL lock_start got=timeout exp=first_byte"); end
        q1.push_back({1'b1, 8'h55});
        wait_idle(500, ok);
        checks++; if (!ok || log_q.size() != 4) begin failures++; $display("FAIL lock_count got=%0d exp=4", log_q.size()); end
        checks++; if (log_q[1] !== 16'h0111 || log_q[2] !== 16'h0112) begin
            failures++; $display("FAIL lock_order got=%h,%h exp=0111,0112", log_q[1], log_q[2]); end
        checks++; if (log_q[3] !== 16'h0255) begin failures++; $display("FAIL lock_port1 got=%h exp=0255", log_q[3]); end
    endtask

    task automatic test_timeout();
        bit ok = 1'b0;
        int t_drop = 0;
        log_q.delete();
        q0.push_back({1'b0, 8'h20});
        for (int i = 0; i < 100; i++) begin
            tick();
            if (log_q.size() >= 1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL to_start got=timeout exp=first_byte"); end
        q1.push_back({1'b1, 8'h66});
        for (int m = 2; m <= 6000; m++) begin
            tick();
            if (grant !== 2'b01) begin t_drop = m; break; end
        end
        checks++; if (t_drop < 4809 || t_drop > 4819) begin
            failures++; $display("FAIL to_drop_cycle got=%0d exp=4814", t_drop); end
        wait_idle(200, ok);
        checks++; if (!ok || log_q.size() != 2 || log_q[0] !== 16'h0120 || log_q[1] !== 16'h0266) begin
            failures++; $display("FAIL to_next_port got=%h,%h n=%0d exp=0120,0266", log_q[0], log_q[1], log_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        bit act_at_grant = 1'b1;
        log_q.delete();
        q0.push_back({1'b1, 8'h77});
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx_active) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL rmid_start got=timeout exp=active"); end
        tick(); tick();
        q1.push_back({1'b1, 8'h88});
        rst = 1'b1;
        tick();
        checks++; if (tx_dv !== 1'b0 || tx_byte !== 8'h00 || grant !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b00) begin
            failures++; $display("FAIL rmid_outputs dv=%b byte=%h grant=%b busy=%b ready=%b exp all 0",
                                 tx_dv, tx_byte, grant, busy, req_ready); end
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (grant != 2'b00) begin ok = 1'b1; act_at_grant = tx_active; break; end
        end
        checks++; if (!ok || act_at_grant !== 1'b0 || grant !== 2'b10) begin
            failures++; $display("FAIL rmid_hold grant=%b active_at_grant=%b exp 10/0", grant, act_at_grant); end
        wait_idle(200, ok);
        checks++; if (!ok || log_q.size() != 2 || log_q[1] !== 16'h0288) begin
            failures++; $display("FAIL rmid_resume got=%h n=%0d exp=0288 n=2", log_q[1], log_q.size()); end
    endtask

`ifdef UART_SCHED_HEX_EN
    task automatic test_hex();
        bit ok;
        log_q.delete();
        q1.push_back({1'b1, 8'h3C});
        wait_idle(300, ok);
        checks++; if (!ok || log_q.size() != 2) begin failures++; $display("FAIL hex_count got=%0d exp=2", log_q.size()); end
        checks++; if (log_q[0] !== 16'h0233 || log_q[1] !== 16'h0243) begin
            failures++; $display("FAIL hex_chars got=%h,%h exp=0233,0243", log_q[0], log_q[1]); end
    endtask
`endif

    task automatic test_invariants();
        checks++; if (ready_bad != 0) begin failures++; $display("FAIL inv_ready got=%0d exp=0", ready_bad); end
        checks++; if (unstable != 0)  begin failures++; $display("FAIL inv_byte_stable got=%0d exp=0", unstable); end
        checks++; if (dv_total != dv_logged) begin
            failures++; $display("FAIL inv_dv_pulses got=%0d exp=%0d", dv_total, dv_logged); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_packet_ok();
        test_simultaneous();
        test_lock();
        test_timeout();
        test_reset_mid();
`ifdef UART_SCHED_HEX_EN
        test_hex();
`endif
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
